// File: rtl/bcd_pkg.sv
// Shared types and constants for the two-digit BCD down counter.
//   state_t       : counter control states (IDLE, RUN, EXPIRED)
//   BCD_MAX_DIGIT : largest legal BCD digit
//   BCD_ZERO      : two-digit BCD zero
//   bcd_legal()   : true when both nibbles of a byte are legal BCD digits
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CNT_W   = 2 * DIGIT_W;

    localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [CNT_W-1:0]   BCD_ZERO      = 8'h00;
    localparam logic [CNT_W-1:0]   BCD_ONE       = 8'h01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    function automatic logic bcd_legal(input logic [CNT_W-1:0] v);
        return (v[7:4] <= BCD_MAX_DIGIT) && (v[3:0] <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// Single BCD digit down counter.
// Ports:
//   clk, rst_n : clock, async active-low reset (digit -> 0)
//   clr        : synchronous clear, highest priority
//   ld, ld_val : synchronous load of a digit value
//   en, bin    : digit steps down when both are high (9 after 0)
//   q          : registered digit value
//   bout_c     : combinational borrow-out, high when q == 0 and en is high
module bcd_digit_dn
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] ld_val,
    input  logic               en,
    input  logic               bin,
    output logic [DIGIT_W-1:0] q,
    output logic               bout_c
);

    assign bout_c = en && (q == DIGIT_W'(0));

    // Digit register: clear > load > step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= DIGIT_W'(0);
        end else if (clr) begin
            q <= DIGIT_W'(0);
        end else if (ld) begin
            q <= ld_val;
        end else if (en && bin) begin
            q <= (q == DIGIT_W'(0)) ? BCD_MAX_DIGIT : q - DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/bcd_dncnt.sv
// Two-digit BCD down counter with load, clear and terminal-count pulse.
// Ports:
//   clk     : system clock, rising edge
//   clrn    : async active-low reset
//   clr_cnt : synchronous clear (priority over ld and dec)
//   ld      : synchronous load of ld_val (priority over dec)
//   ld_val  : load value, [7:4] tens, [3:0] units
//   dec     : decrement enable, effective only in RUN
//   cnt     : registered two-digit BCD count
//   zero    : combinational, cnt == 0x00
//   tc      : registered one-cycle pulse when the count reaches 0x00 by decrement
//   ld_err  : registered one-cycle pulse on a load with an illegal BCD digit
module bcd_dncnt
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             clrn,
    input  logic             clr_cnt,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             tc,
    output logic             ld_err
);

    state_t state_q;
    state_t state_d;
    logic   tc_d;
    logic   ld_err_d;

    logic               ld_ok_c;
    logic               dec_go_c;
    logic               tens_en_c;
    logic               u_bout_c;
    logic               t_bout_c;
    logic [DIGIT_W-1:0] units_q;
    logic [DIGIT_W-1:0] tens_q;

    assign cnt  = {tens_q, units_q};
    assign zero = (cnt == BCD_ZERO);

    // Load only takes effect with legal digits; clear priority lives in the digits
    assign ld_ok_c  = ld && bcd_legal(ld_val);
    // Decrement only in RUN, never from zero, and never alongside clear/load
    assign dec_go_c = dec && !clr_cnt && !ld && (state_q == RUN) && !zero;
    // Tens steps on a units borrow while running
    assign tens_en_c = u_bout_c && (state_q == RUN);

    bcd_digit_dn u_units (
        .clk    (clk),
        .rst_n  (clrn),
        .clr    (clr_cnt),
        .ld     (ld_ok_c),
        .ld_val (ld_val[3:0]),
        .en     (dec_go_c),
        .bin    (1'b1),
        .q      (units_q),
        .bout_c (u_bout_c)
    );

    bcd_digit_dn u_tens (
        .clk    (clk),
        .rst_n  (clrn),
        .clr    (clr_cnt),
        .ld     (ld_ok_c),
        .ld_val (ld_val[7:4]),
        .en     (tens_en_c),
        .bin    (1'b1),
        .q      (tens_q),
        .bout_c (t_bout_c)
    );

    // State and pulse registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            tc      <= 1'b0;
            ld_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            tc      <= tc_d;
            ld_err  <= ld_err_d;
        end
    end

    // Next state and pulse decode, priority clr_cnt > ld > dec
    always_comb begin
        state_d  = state_q;
        tc_d     = 1'b0;
        ld_err_d = 1'b0;
        if (clr_cnt) begin
            state_d = IDLE;
        end else if (ld) begin
            if (ld_ok_c) begin
                state_d = (ld_val == BCD_ZERO) ? EXPIRED : RUN;
            end else begin
                ld_err_d = 1'b1;
            end
        end else if (dec_go_c && (cnt == BCD_ONE)) begin
            state_d = EXPIRED;
            tc_d    = 1'b1;
        end else if (t_bout_c) begin
            // A tens borrow would mean wrapping past zero; park in EXPIRED
            state_d = EXPIRED;
        end
    end

endmodule

// File: doc/bcd_dncnt.md
BCD_DNCNT -- requirements
Module: bcd_dncnt

Interface
REQ-001 The block SHALL have these ports: CLK, input, 1, system clock; all state updates on the rising edge.
REQ-002 The block SHALL have these ports: CLRN, input, 1, reset; asynchronous, active-low.
REQ-003 The block SHALL have these ports: CLR_CNT, input, 1, synchronous clear; active high.
REQ-004 The block SHALL have these ports: LD, input, 1, synchronous load of LD_VAL; active high.
REQ-005 The block SHALL have these ports: LD_VAL, input, 8, load value; two BCD digits, [7:4] tens and [3:0] units.
REQ-006 The block SHALL have these ports: DEC, input, 1, decrement enable; sampled on each rising CLK edge.
REQ-007 The block SHALL have these ports: CNT, output, 8, current count; two-digit BCD, registered.
REQ-008 The block SHALL have these ports: ZERO, output, 1, combinational indication that CNT equals 0x00.
REQ-009 The block SHALL have these ports: TC, output, 1, registered one-cycle terminal-count pulse.
REQ-010 The block SHALL have these ports: LD_ERR, output, 1, registered one-cycle pulse flagging an illegal BCD load value.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, RUN and EXPIRED.
REQ-012 Per clock edge, controls SHALL take priority in the order CLR_CNT, then LD, then DEC.
REQ-013 CLR_CNT=1 SHALL set CNT to 0x00 and the state to IDLE, and SHALL leave TC and LD_ERR at 0, regardless of LD and DEC.
REQ-014 LD=1 with both LD_VAL nibbles no greater than 9 SHALL load CNT=LD_VAL on that edge.
REQ-015 After a legal load, the state SHALL go to RUN if LD_VAL is nonzero, or to EXPIRED if LD_VAL is 0x00; no TC pulse SHALL be generated by a load.
REQ-016 LD=1 with either nibble greater than 9 SHALL leave CNT and the state unchanged and SHALL pulse LD_ERR high for exactly the following cycle.
REQ-017 DEC=1 in RUN SHALL decrement CNT by one in BCD: a units digit of 0 becomes 9 and borrows 1 from tens; otherwise units decrements and tens is held.
REQ-018 A decrement from 0x01 to 0x00 SHALL set TC=1 in the same cycle that CNT becomes 0x00, and the state SHALL go to EXPIRED.
REQ-019 TC SHALL be 1 for exactly one cycle per expiry.
REQ-020 DEC=1 in IDLE or EXPIRED SHALL leave CNT unchanged: no wrap from 0x00 to 0x99, and no TC.
REQ-021 DEC=0 SHALL hold CNT and the state.
REQ-022 A legal LD in EXPIRED or RUN SHALL restart the count, with the state going to RUN or EXPIRED per REQ-015.
REQ-023 CNT SHALL always hold legal BCD digits 0-9.
REQ-024 ZERO SHALL equal (CNT == 0x00) with no added latency.
REQ-025 Load-to-CNT latency SHALL be 1 cycle, and decrement-to-CNT latency SHALL be 1 cycle.

Reset
REQ-026 CLRN=0 SHALL immediately, without waiting for CLK, force CNT=0x00, state=IDLE, TC=0 and LD_ERR=0.
REQ-027 Reset asserted mid-count SHALL abort the count, and no TC SHALL be produced on release.
REQ-028 After CLRN rises, the block SHALL respond to controls from the first subsequent rising CLK edge.

Structure
REQ-029 A shared package bcd_pkg SHALL hold the state enum type (IDLE, RUN, EXPIRED) and the constants BCD_MAX_DIGIT=4'd9 and BCD_ZERO=8'h00.
REQ-030 The block SHALL instantiate two copies of a sub-module bcd_digit_dn, one for units and one for tens.
REQ-031 bcd_digit_dn SHALL provide a single-digit down counter with load, enable, borrow-in and borrow-out, where borrow-out is asserted when the digit is 0 and enable is high.
REQ-032 The tens digit SHALL be enabled by the units borrow-out, gated by the RUN state.

Verification
REQ-033 Scenario 1 SHALL apply CLRN=0 while DEC=1, then release CLRN and hold DEC=1 for 3 cycles, and SHALL require CNT=0x00, ZERO=1 and TC=0 throughout.
REQ-034 Scenario 2 SHALL apply LD with LD_VAL=0x12 followed by DEC=1 for 3 cycles, and SHALL require CNT to read 0x12, then 0x11, 0x10, 0x09, with the 0x10-to-0x09 step exercising the borrow.
REQ-035 Scenario 3 SHALL apply LD with LD_VAL=0x02 followed by DEC=1 for 4 cycles, and SHALL require CNT to read 0x01, then 0x00 with TC=1 for exactly that one cycle, then 0x00 held with TC=0.
REQ-036 Scenario 4 SHALL apply LD with LD_VAL=0x3A while CNT=0x05, and SHALL require CNT to stay 0x05 and LD_ERR=1 for exactly one cycle; the same check SHALL be repeated with LD_VAL=0xA3.
REQ-037 Scenario 5 SHALL apply CLR_CNT=1 and LD=1 with LD_VAL=0x50 in the same cycle while CNT=0x07 in RUN, and SHALL require CNT=0x00 with state IDLE; a following DEC SHALL leave CNT at 0x00.
REQ-038 Scenario 6 SHALL apply LD with LD_VAL=0x00, and SHALL require state EXPIRED, ZERO=1 and TC=0; a subsequent LD with LD_VAL=0x99 followed by DEC SHALL give CNT=0x98.
